// File: rtl/sort_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : sort_sequencer                                                    |
// | Purpose : Places three sensed blocks into the slots named by a latched      |
// |           colour-order word using a req/done mechanism handshake.          |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module sort_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] block_position,
  input  logic       color_valid,
  input  logic [1:0] color_code,
  input  logic       move_done,
  output logic       move_req,
  output logic [1:0] target_slot,
  output logic [1:0] placed_count,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CHECK      = 3'd1,
    S_WAIT_COLOR = 3'd2,
    S_WAIT_ACK   = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } state_t;

  localparam logic [1:0]       c_ERR_NONE    = 2'b00;
  localparam logic [1:0]       c_ERR_ORDER   = 2'b01;
  localparam logic [1:0]       c_ERR_COLOR   = 2'b10;
  localparam logic [1:0]       c_ERR_TIMEOUT = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_order;
  logic [2:0]       r_filled;
  logic [CNT_W-1:0] r_cnt;
  logic             r_move_req;
  logic [1:0]       r_target_slot;
  logic [1:0]       r_placed_count;
  logic [1:0]       r_err_code;

  logic [1:0] w_code0, w_code1, w_code2;
  logic       w_order_bad;
  logic [2:0] w_match;
  logic       w_color_ok;
  logic [1:0] w_hit_slot;
  logic       w_latch, w_launch, w_complete, w_cnt_inc, w_err;
  logic [1:0] w_err_code;

  assign w_code0 = r_order[5:4];
  assign w_code1 = r_order[3:2];
  assign w_code2 = r_order[1:0];

  // A legal order is a permutation of the three non-zero colour codes.
  assign w_order_bad = (w_code0 == 2'b00) || (w_code1 == 2'b00) || (w_code2 == 2'b00) ||
                       (w_code0 == w_code1) || (w_code0 == w_code2) || (w_code1 == w_code2);

  assign w_match    = {color_code == w_code2, color_code == w_code1, color_code == w_code0};
  assign w_color_ok = (color_code != 2'b00) && (w_match != 3'b000) && ((w_match & r_filled) == 3'b000);
  assign w_hit_slot = w_match[0] ? 2'd0 : (w_match[1] ? 2'd1 : 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_launch    = 1'b0;
    w_complete  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err       = 1'b0;
    w_err_code  = c_ERR_NONE;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt = S_CHECK;
          w_latch     = 1'b1;
        end
      end
      S_CHECK: begin
        if (w_order_bad) begin
          w_state_nxt = S_ERROR;
          w_err       = 1'b1;
          w_err_code  = c_ERR_ORDER;
        end else begin
          w_state_nxt = S_WAIT_COLOR;
        end
      end
      S_WAIT_COLOR: begin
        if (color_valid) begin
          if (w_color_ok) begin
            w_state_nxt = S_WAIT_ACK;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = S_ERROR;
            w_err       = 1'b1;
            w_err_code  = c_ERR_COLOR;
          end
        end
      end
      S_WAIT_ACK: begin
        // A completion arriving on the last allowed cycle beats the timeout.
        if (move_done) begin
          w_complete  = 1'b1;
          w_state_nxt = (r_placed_count == 2'd2) ? S_DONE : S_WAIT_COLOR;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_ERROR;
          w_err       = 1'b1;
          w_err_code  = c_ERR_TIMEOUT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_order        <= 6'd0;
      r_filled       <= 3'b000;
      r_cnt          <= '0;
      r_move_req     <= 1'b0;
      r_target_slot  <= 2'd0;
      r_placed_count <= 2'd0;
      r_err_code     <= c_ERR_NONE;
    end else begin
      if (w_latch) begin
        r_order        <= block_position;
        r_filled       <= 3'b000;
        r_placed_count <= 2'd0;
        r_err_code     <= c_ERR_NONE;
      end
      if (w_launch) begin
        r_target_slot <= w_hit_slot;
        r_move_req    <= 1'b1;
        r_cnt         <= '0;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_complete) begin
        r_move_req     <= 1'b0;
        r_filled       <= r_filled | (3'b001 << r_target_slot);
        r_placed_count <= r_placed_count + 2'd1;
      end
      if (w_err) begin
        r_err_code <= w_err_code;
        r_move_req <= 1'b0;
      end
    end
  end

  assign move_req     = r_move_req;
  assign target_slot  = r_target_slot;
  assign placed_count = r_placed_count;
  assign err_code     = r_err_code;
  assign busy         = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign done         = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- Downstream consumer of the colour-order selector's 6-bit block_position word: three 2-bit colour codes, slot 0 = [5:4], slot 1 = [3:2], slot 2 = [1:0].
- Colour codes: 01 red, 10 green, 11 blue, 00 invalid.
- Latches the selected order on start and takes blocks reported by the colour sensor.
- For each block, commands the placement mechanism to the matching slot over a req/done handshake, and flags duplicates, bad orders and mechanism timeouts.

Parameters:
TIMEOUT_CYCLES, 1000000, max cycles move_req may stay high without move_done before error (≥2)
CNT_W, 20, width of timeout counter; 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a 3-block sort run; sampled only in IDLE, DONE, ERROR
block_position  input  6  target order from selector, latched on accepted start
color_valid  input  1  one-cycle strobe: sensor has classified a block
color_code  input  2  colour of sensed block, valid with color_valid
move_done  input  1  mechanism finished current move (level or pulse)
move_req  output  1  request mechanism move; held high until move_done
target_slot  output  2  slot for current move (0..2), stable while move_req high
placed_count  output  2  blocks placed this run (0..3)
busy  output  1  high in all states except IDLE, DONE, ERROR
done  output  1  high in DONE
error  output  1  high in ERROR
err_code  output  2  00 none, 01 bad order word, 10 bad/duplicate colour, 11 timeout

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, order register=0, filled mask=000, timeout counter=0.
- States: IDLE, CHECK, WAIT_COLOR, WAIT_ACK, DONE, ERROR.
- IDLE/DONE/ERROR + start=1:
  - Next edge: latch block_position, clear filled mask, placed_count=0, err_code=00.
  - Enter CHECK; done and error drop on the same edge.
- CHECK (1 cycle):
  - Any slot code 00, or any two slots equal -> ERROR, err_code=01.
  - Otherwise -> WAIT_COLOR.
- WAIT_COLOR:
  - color_valid=0: stay.
  - color_valid=1: slot = index where order[slot]==color_code.
  - No match, color_code=00, or slot already in filled mask -> ERROR, err_code=10.
  - Otherwise, next edge: target_slot=slot, move_req=1, timeout counter=0 -> WAIT_ACK.
- WAIT_ACK:
  - color_valid ignored; no sensor buffering, so the sensor must not strobe while busy in WAIT_ACK.
  - move_done=1: next edge move_req=0, filled[slot]=1, placed_count+1.
    - New count=3 -> DONE.
    - Otherwise -> WAIT_COLOR.
  - Counter increments each cycle move_done=0. Reaching TIMEOUT_CYCLES-1 with move_done=0 -> ERROR, err_code=11, move_req=0.
  - move_done and timeout in the same cycle: move_done wins.
- move_done outside WAIT_ACK: ignored.
- target_slot holds last value after move_req drops.
- DONE: done=1, placed_count=3, held until start or rst.
- ERROR: error=1 and err_code held; placed_count frozen; move_req=0; exit only via start or rst.
- start while busy: ignored.
- Latency:
  - start to move_req-eligible: 2 cycles (latch, CHECK).
  - color_valid to move_req high: 1 edge.
  - move_done to move_req low: 1 edge.
- rst mid-move: move_req falls asynchronously; the mechanism must tolerate an aborted request.

Test Plan:
- Order 011011; start; colours 11, 01, 10 with move_done 3 cycles after each req -> target_slot 2, 0, 1; placed_count 1, 2, 3; done=1; move_req high exactly 3 times.
- Order 011110; colours 01 then 01 -> first move to slot 0 completes; second strobe -> error=1, err_code=10, placed_count=1, no second move_req.
- Order 010111 (duplicate red) -> ERROR 2 cycles after start, err_code=01, move_req never asserted; order 001011 -> same.
- TIMEOUT_CYCLES=8; order 100111; colour 10; move_done held 0 -> move_req high 8 cycles then error=1, err_code=11, move_req=0. Variant with move_done on the final cycle -> no error.
- Assert rst while move_req=1 in WAIT_ACK -> all outputs 0 immediately. After release, start with 111001 and colours 01, 10, 11 -> slots 2, 1, 0, done=1.
- From DONE, start with 101101 -> done clears next edge, placed_count=0; color_valid during WAIT_ACK is ignored with no state change; start pulses while busy have no effect.
